// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue: op encodings, bubble
// instruction and the one-hot legality helper.
package alu_issue_queue_pkg;

  localparam int INSTR_W = 8;

  // Bit index of each ALU op inside the one-hot instruction word.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_XNOR = 3'd7
  } alu_op_e;

  // Driven into the pipeline on empty cycles; a harmless ADD.
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 8'b0000_0001;

  // True when exactly one bit is set: non-zero and clearing the lowest
  // set bit leaves nothing behind.
  function automatic logic is_onehot8(input logic [INSTR_W-1:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

  // One-hot instruction word for a given op.
  function automatic logic [INSTR_W-1:0] op_to_instr(input alu_op_e op);
    return 8'b0000_0001 << op;
  endfunction

endpackage

// File: rtl/alu_issue_queue_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; only valid slots are ever read, so contents need no init.
  // NOTE: memory arrays are left out of reset so they map onto plain RAM/regfile cells.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: clocked state uses <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU parity pipeline: buffers requests, drops
// non-one-hot instructions, issues one request or bubble per cycle and
// tracks which pipeline parity outputs belong to real requests.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 8,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_A,
  input  logic [OP_W-1:0]    in_B,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               issue_enable,
  output logic [OP_W-1:0]    A_out,
  output logic [OP_W-1:0]    B_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               issue_valid,
  output logic               parity_valid,
  output logic               illegal_pulse,
  output logic [CNT_W-1:0]   illegal_count,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int ENTRY_W = 2*OP_W + INSTR_W;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               drop;
  logic [1:0]         vshift;

  // Ready depends on stored occupancy only, so a full queue refuses a push
  // even when a pop happens on the same edge.
  assign in_ready = !fifo_full;

  // Handshake decode: legal requests are stored, illegal ones are dropped.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept = 1'b0;
    push   = 1'b0;
    drop   = 1'b0;
    pop    = 1'b0;
    accept = in_valid && in_ready;
    if (accept) begin
      if (is_onehot8(in_instr)) push = 1'b1;
      else                      drop = 1'b1;
    end
    pop = !fifo_empty && issue_enable;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_A, in_B, in_instr}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // Issue registers: load the head on a pop, otherwise issue a bubble while
  // holding the previous operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      A_out       <= '0;
      B_out       <= '0;
      instr_out   <= BUBBLE_INSTR;
      issue_valid <= 1'b0;
    end else if (pop) begin
      A_out       <= head[ENTRY_W-1 -: OP_W];
      B_out       <= head[INSTR_W +: OP_W];
      instr_out   <= head[INSTR_W-1:0];
      issue_valid <= 1'b1;
    end else begin
      instr_out   <= BUBBLE_INSTR;
      issue_valid <= 1'b0;
    end
  end

  // Illegal-request reporting: one-cycle pulse plus a saturating counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_pulse <= 1'b0;
      illegal_count <= '0;
    end else begin
      illegal_pulse <= drop;
      if (drop && (illegal_count != '1)) illegal_count <= illegal_count + 1'b1;
    end
  end

  // Valid shift mirroring the pipeline's two register stages.
  always_ff @(posedge clock) begin
    if (reset) vshift <= 2'b00;
    else       vshift <= {vshift[0], issue_valid};
  end

  assign parity_valid = vshift[1];

endmodule
